// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// opcodes, funct codes, ALU control codes, aluop selectors and state encoding.
package multicycle_ctrl_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned ALUOP_W    = 2;
    localparam int unsigned ST_W       = 4;

    // Opcodes, instruction[31:26]
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes, instruction[5:0]
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // ALU control codes, shared with the ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;
    localparam logic [ALU_CTRL_W-1:0] ALU_X   = 3'b011;

    // FSM request to the ALU decoder; 11 forces the invalid code
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_X     = 2'b11;

    // ALU B-operand and next-PC selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    // Datapath control bundle driven by the FSM each cycle
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's aluop request (and funct for R-type) onto the
// 3-bit ALU control code, flagging funct values the ALU does not support.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [ALUOP_W-1:0]    aluop,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  funct_valid
);

    logic [ALU_CTRL_W-1:0] funct_code;

    // R-type funct lookup
    always_comb begin
        funct_code  = ALU_X;
        funct_valid = 1'b0;
        case (funct)
            FUNCT_ADD: begin funct_code = ALU_ADD; funct_valid = 1'b1; end
            FUNCT_SUB: begin funct_code = ALU_SUB; funct_valid = 1'b1; end
            FUNCT_AND: begin funct_code = ALU_AND; funct_valid = 1'b1; end
            FUNCT_OR:  begin funct_code = ALU_OR;  funct_valid = 1'b1; end
            FUNCT_SLT: begin funct_code = ALU_SLT; funct_valid = 1'b1; end
            default:   begin funct_code = ALU_X;   funct_valid = 1'b0; end
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_code;
            default:     alu_control = ALU_X;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Moore outputs decoded from the state
// register; pc_en alone folds in the ALU zero flag for conditional branches.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_W-1:0]       op,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic                  zero,
    output logic                  pc_en,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic [STATE_W-1:0]    state
);

    state_e              state_q;
    state_e              state_d;
    logic                is_sw_q;
    logic                is_sw_d;
    ctrl_t               ctrl;
    logic [ALUOP_W-1:0]  aluop;
    logic                funct_valid;

    // is_sw_q remembers lw vs sw so MEMADR never re-reads op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        is_sw_d = is_sw_q;
        ctrl    = '0;
        aluop   = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                if (is_mem_op(op)) begin
                    state_d = S_MEMADR;
                    is_sw_d = (op == OP_SW);
                end else begin
                    case (op)
                        OP_RTYPE: state_d = S_EXECUTE;
                        OP_BEQ:   state_d = S_BRANCH;
                        OP_ADDI:  state_d = S_ADDIEX;
                        OP_J:     state_d = S_JUMP;
                        default:  state_d = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                aluop          = ALUOP_FUNCT;
                state_d        = funct_valid ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
                aluop          = ALUOP_SUB;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
                aluop        = ALUOP_X;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .aluop       (aluop),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign illegal    = ctrl.illegal;
    assign state      = STATE_W'(state_q);

endmodule
